verdma: RTL and testbench

VERDMA -- requirements
Module: verdma

---
 rtl/verdma.sv | 162 ++++++++++++++++
 tb/tb_verdma.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/verdma.sv
// verdma: single-channel memory-to-memory word copier.
//   cfg_*      : register port, always ready (SRC, DST, COUNT, CTRL/STATUS at [3:2])
//   m_*        : initiator port; one read then one write per 32-bit word
//   m_lookahead: the m_address that will be presented on the next cycle
//   irq        : done && ie
//
// state | meaning
// IDLE  | no bus request; m_address shows SRC
// READ  | reading word at SRC into the buffer
// WRITE | writing buffer to DST, then advance pointers and count
module verdma #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [31:0] cfg_address,
  input  logic [3:0]  cfg_wstrobe,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  output logic        irq,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_address,
  output logic [31:0] m_lookahead,
  output logic [3:0]  m_wstrobe,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t                 state_q, state_d;
  logic [31:0]            src_q, src_d;
  logic [31:0]            dst_q, dst_d;
  logic [31:0]            buf_q, buf_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   done_q, done_d;
  logic                   ie_q, ie_d;

  logic        busy;
  logic        cfg_wr;
  logic        ctrl_wr;
  logic        start;
  logic [1:0]  reg_sel;
  logic [31:0] wr_merge;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{cfg_address[31:4], cfg_address[1:0]};

  assign busy    = (state_q != IDLE);
  assign reg_sel = cfg_address[3:2];
  assign cfg_wr  = cfg_valid && (cfg_wstrobe != 4'b0000);
  assign ctrl_wr = cfg_wr && (reg_sel == 2'd3) && cfg_wstrobe[0];
  assign start   = ctrl_wr && cfg_wdata[0] && !busy;

  // Byte-lane merge of write data over the currently addressed register.
  always_comb begin
    wr_merge = cfg_rdata;
    for (int i = 0; i < 4; i++) begin
      if (cfg_wstrobe[i]) wr_merge[8*i +: 8] = cfg_wdata[8*i +: 8];
    end
  end

  always_comb begin
    cfg_ready = 1'b1;
    case (reg_sel)
      2'd0:    cfg_rdata = src_q;
      2'd1:    cfg_rdata = dst_q;
      2'd2:    cfg_rdata = 32'(count_q);
      default: cfg_rdata = {29'd0, ie_q, done_q, busy};
    endcase
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    buf_d   = buf_q;
    count_d = count_q;
    done_d  = done_q;
    ie_d    = ie_q;

    if (cfg_wr && !busy) begin
      case (reg_sel)
        2'd0:    src_d   = {wr_merge[31:2], 2'b00};
        2'd1:    dst_d   = {wr_merge[31:2], 2'b00};
        2'd2:    count_d = COUNT_WIDTH'(wr_merge);
        default: ;
      endcase
    end

    // Clear is applied before start so a combined clear+start of an empty
    // transfer still ends with done set.
    if (ctrl_wr) begin
      ie_d = cfg_wdata[2];
      if (cfg_wdata[1]) done_d = 1'b0;
    end
    if (start) begin
      if (count_q == '0) done_d = 1'b1;
      else               state_d = READ;
    end

    case (state_q)
      READ: begin
        if (m_ready) begin
          buf_d   = m_rdata;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (m_ready) begin
          src_d = src_q + 32'd4;
          dst_d = dst_q + 32'd4;
          if (count_q != '0) count_d = count_q - COUNT_WIDTH'(1);
          if (count_q <= COUNT_WIDTH'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = READ;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    m_valid   = (state_q != IDLE);
    m_address = (state_q == WRITE) ? dst_q : src_q;
    m_wstrobe = (state_q == WRITE) ? 4'b1111 : 4'b0000;
    m_wdata   = buf_q;
    irq       = done_q && ie_q;
    case (state_q)
      READ:    m_lookahead = m_ready ? dst_q : src_q;
      WRITE:   m_lookahead = m_ready ? (src_q + 32'd4) : dst_q;
      default: m_lookahead = src_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      buf_q   <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      ie_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      buf_q   <= buf_d;
      count_q <= count_d;
      done_q  <= done_d;
      ie_q    <= ie_d;
    end
  end

endmodule

// File: tb/tb_verdma.sv
module tb_verdma;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_address;
  logic [3:0]  cfg_wstrobe;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        irq;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_address;
  logic [31:0] m_lookahead;
  logic [3:0]  m_wstrobe;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;

  int n_checks = 0;
  int n_errors = 0;

  // Responder model: read data equals the read address.
  logic [31:0] wmem [logic [31:0]];
  logic [31:0] rd_log [$];
  int          n_writes = 0;
  int          mv_cycles = 0;
  int          stall = 0;
  int          wait_cnt = 0;
  bit          prev_stall = 0;
  logic [31:0] sv_addr, sv_data;
  logic [3:0]  sv_strb;
  bit          la_valid = 0;
  logic [31:0] la_prev;

  assign m_rdata = m_address;

  verdma #(.COUNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_address(cfg_address),
    .cfg_wstrobe(cfg_wstrobe), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .irq(irq),
    .m_valid(m_valid), .m_ready(m_ready), .m_address(m_address),
    .m_lookahead(m_lookahead), .m_wstrobe(m_wstrobe), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    if (m_valid) mv_cycles++;
    if (m_valid && m_ready && !reset) begin
      if (m_wstrobe == 4'b0000) rd_log.push_back(m_address);
      else begin
        wmem[m_address] = m_wdata;
        n_writes++;
      end
      wait_cnt = 0;
    end else if (m_valid) begin
      wait_cnt++;
    end else begin
      wait_cnt = 0;
    end
    prev_stall = m_valid && !m_ready && !reset;
    sv_addr = m_address;
    sv_data = m_wdata;
    sv_strb = m_wstrobe;
    if (reset) la_valid = 0;
  end

  always @(negedge clk) begin
    if (la_valid) chk("lookahead", m_address, la_prev);
    if (prev_stall && m_valid) begin
      chk("stall_addr", m_address, sv_addr);
      chk("stall_data", m_wdata, sv_data);
      chk("stall_strb", 32'(m_wstrobe), 32'(sv_strb));
    end
    m_ready = m_valid && (wait_cnt >= stall);
    #1;
    la_prev  = m_lookahead;
    la_valid = m_valid;
  end

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
    cfg_valid   = 1'b1;
    cfg_address = {28'h0, a, 2'b00};
    cfg_wdata   = d;
    cfg_wstrobe = s;
    @(negedge clk);
    cfg_valid   = 1'b0;
    cfg_wstrobe = 4'b0000;
  endtask

  task automatic cfg_read(input logic [1:0] a, output logic [31:0] d);
    cfg_valid   = 1'b1;
    cfg_wstrobe = 4'b0000;
    cfg_address = {28'h0, a, 2'b00};
    #1;
    d = cfg_rdata;
    cfg_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] s;
    bit ok;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      cfg_read(2'd3, s);
      if (s[0] == 1'b0) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic setup(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] cnt);
    cfg_write(2'd0, src, 4'hF);
    cfg_write(2'd1, dst, 4'hF);
    cfg_write(2'd2, cnt, 4'hF);
    wmem.delete();
    rd_log.delete();
    n_writes  = 0;
    mv_cycles = 0;
  endtask

  initial begin
    logic [31:0] r;
    bit ok;
    reset       = 1'b1;
    cfg_valid   = 1'b0;
    cfg_address = '0;
    cfg_wstrobe = '0;
    cfg_wdata   = '0;
    m_ready     = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("cfg_ready", 32'(cfg_ready), 32'd1);
    reset = 1'b0;
    cfg_read(2'd3, r); chk("rst_status", r, 32'd0);
    cfg_read(2'd2, r); chk("rst_count", r, 32'd0);
    @(negedge clk);

    // SRC low bits and per-lane COUNT writes
    cfg_write(2'd0, 32'hFFFF_FFFF, 4'hF);
    cfg_read(2'd0, r); chk("src_low_bits", r, 32'hFFFF_FFFC);
    @(negedge clk);
    cfg_write(2'd2, 32'hABCD_1234, 4'b0001);
    cfg_write(2'd2, 32'h0000_5600, 4'b0010);
    cfg_read(2'd2, r); chk("count_lanes", r, 32'h0000_5634);
    @(negedge clk);

    // Zero-wait three-word copy
    stall = 0;
    setup(32'h100, 32'h200, 32'd3);
    cfg_write(2'd3, 32'h1, 4'h1);
    wait_idle("t1_timeout");
    chk("t1_mv_cycles", 32'(mv_cycles), 32'd6);
    chk("t1_reads", 32'(rd_log.size()), 32'd3);
    chk("t1_w200", wmem[32'h200], 32'h100);
    chk("t1_w204", wmem[32'h204], 32'h104);
    chk("t1_w208", wmem[32'h208], 32'h108);
    cfg_read(2'd3, r); chk("t1_status", r, 32'h2);
    cfg_read(2'd2, r); chk("t1_count", r, 32'd0);
    cfg_read(2'd0, r); chk("t1_src", r, 32'h10C);
    cfg_read(2'd1, r); chk("t1_dst", r, 32'h20C);
    chk("t1_irq", 32'(irq), 32'd0);
    @(negedge clk);

    // Same copy with a two-cycle stall per request
    stall = 2;
    setup(32'h100, 32'h200, 32'd3);
    cfg_write(2'd3, 32'h3, 4'h1);
    wait_idle("t2_timeout");
    chk("t2_reads", 32'(rd_log.size()), 32'd3);
    chk("t2_writes", 32'(n_writes), 32'd3);
    chk("t2_w200", wmem[32'h200], 32'h100);
    chk("t2_w204", wmem[32'h204], 32'h104);
    chk("t2_w208", wmem[32'h208], 32'h108);
    cfg_read(2'd3, r); chk("t2_status", r, 32'h2);
    cfg_read(2'd2, r); chk("t2_count", r, 32'd0);
    @(negedge clk);

    // Empty transfer with interrupt enabled
    stall = 0;
    setup(32'h100, 32'h200, 32'd0);
    cfg_write(2'd3, 32'h7, 4'h1);
    cfg_read(2'd3, r); chk("t3_status", r, 32'h6);
    chk("t3_irq", 32'(irq), 32'd1);
    chk("t3_no_bus", 32'(mv_cycles), 32'd0);
    @(negedge clk);
    cfg_write(2'd3, 32'h2, 4'h1);
    chk("t3_irq_clr", 32'(irq), 32'd0);
    cfg_read(2'd3, r); chk("t3_status_clr", r, 32'h0);
    @(negedge clk);

    // Source address wraps past 2^32
    setup(32'hFFFF_FFFC, 32'h300, 32'd2);
    cfg_write(2'd3, 32'h3, 4'h1);
    wait_idle("t4_timeout");
    chk("t4_reads", 32'(rd_log.size()), 32'd2);
    chk("t4_rd0", rd_log[0], 32'hFFFF_FFFC);
    chk("t4_rd1", rd_log[1], 32'h0000_0000);
    chk("t4_w300", wmem[32'h300], 32'hFFFF_FFFC);
    chk("t4_w304", wmem[32'h304], 32'h0000_0000);
    cfg_read(2'd0, r); chk("t4_src", r, 32'h4);
    @(negedge clk);

    // DST write and restart while busy are ignored
    stall = 2;
    setup(32'h100, 32'h200, 32'd3);
    cfg_write(2'd3, 32'h3, 4'h1);
    cfg_write(2'd1, 32'h500, 4'hF);
    cfg_write(2'd3, 32'h1, 4'h1);
    cfg_read(2'd3, r); chk("t5_busy", r, 32'h1);
    @(negedge clk);
    wait_idle("t5_timeout");
    chk("t5_writes", 32'(n_writes), 32'd3);
    chk("t5_w208", wmem[32'h208], 32'h108);
    chk("t5_no_500", 32'(wmem.exists(32'h500)), 32'd0);
    cfg_read(2'd1, r); chk("t5_dst", r, 32'h20C);
    repeat (4) @(negedge clk);
    chk("t5_idle_after", 32'(m_valid), 32'd0);

    // Reset during WRITE
    setup(32'h100, 32'h200, 32'd3);
    cfg_write(2'd3, 32'h5, 4'h1);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (m_valid && m_wstrobe == 4'hF) begin
        ok = 1;
        break;
      end
    end
    chk("t6_reach_write", 32'(ok), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_m_valid", 32'(m_valid), 32'd0);
    chk("t6_buf", m_wdata, 32'd0);
    mv_cycles = 0;
    cfg_read(2'd0, r); chk("t6_src", r, 32'd0);
    cfg_read(2'd1, r); chk("t6_dst", r, 32'd0);
    cfg_read(2'd2, r); chk("t6_count", r, 32'd0);
    cfg_read(2'd3, r); chk("t6_status", r, 32'd0);
    repeat (5) @(negedge clk);
    chk("t6_no_bus", 32'(mv_cycles), 32'd0);
    chk("t6_irq", 32'(irq), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
